// File: rtl/conv_pkg.sv
// conv_pkg: shared types, sizes and pixel conversion for the convolution result writer.
// Build with CONV_WR_ABS_MODE_EN defined to keep edge magnitude (|x|) instead of clamping negatives.
package conv_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
  localparam int PIX_W = 8;
  localparam int WORD_W = 32;
  localparam int LANES = 4;
  function automatic logic [PIX_W-1:0] to_pixel(input logic signed [PIX_W-1:0] x);
`ifdef CONV_WR_ABS_MODE_EN
    return x[PIX_W-1] ? -x : x;
`else
    return x[PIX_W-1] ? '0 : x;
`endif
  endfunction
endpackage

// File: rtl/conv_result_writer_if.sv
// conv_result_writer_if: word write port toward the output image memory.
interface conv_result_writer_if import conv_pkg::*; #(parameter int ADDR_W = 12) ();
  logic mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [WORD_W-1:0] mem_wr_data;
  logic mem_wr_ready;
  modport master(output mem_wr_en, mem_wr_addr, mem_wr_data, input mem_wr_ready);
  modport slave(input mem_wr_en, mem_wr_addr, mem_wr_data, output mem_wr_ready);
endinterface

// File: rtl/conv_word_fifo.sv
// conv_word_fifo: synchronous word FIFO; a push while full is accepted only alongside a pop.
module conv_word_fifo import conv_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: rtl/conv_result_writer.sv
// conv_result_writer: packs converted convolution sums four per word and streams them to image memory.
module conv_result_writer import conv_pkg::*; #(
  parameter int OUT_W = 62,
  parameter int OUT_H = 62,
  parameter int ADDR_W = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [PIX_W-1:0]     data_in,
  input  logic                 data_valid,
  conv_result_writer_if.master mem,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overflow
);
  localparam int N_PIX = OUT_W * OUT_H;
  localparam int CW = $clog2(N_PIX + 1);
  localparam int IW = $clog2(LANES);
  state_t state, state_nxt;
  logic [CW-1:0] pix_cnt;
  logic [IW-1:0] idx;
  logic [WORD_W-1:0] word, dout;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0] pix;
  logic push_q, take, last, pop, full, empty;
  assign pix = to_pixel(data_in);
  assign take = state == COLLECT && data_valid;
  assign last = take && pix_cnt == CW'(N_PIX - 1);
  assign pop = !empty && mem.mem_wr_ready;
  assign mem.mem_wr_en = !empty;
  assign mem.mem_wr_addr = addr;
  assign mem.mem_wr_data = empty ? '0 : dout;
  conv_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push_q),
    .pop(pop),
    .din(word),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_nxt = state;
    busy = state != IDLE;
    frame_done = state == DONE;
    case (state)
      IDLE:    state_nxt = start ? COLLECT : IDLE;
      COLLECT: state_nxt = last ? DRAIN : COLLECT;
      DRAIN:   state_nxt = (!push_q && empty) ? DONE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  // The final pixel always schedules a push, so a partial tail word is flushed as DRAIN begins.
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      pix_cnt <= '0;
      idx <= '0;
      word <= '0;
      push_q <= 1'b0;
      addr <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      push_q <= take && (idx == IW'(LANES - 1) || last);
      if (state == IDLE && start) begin
        pix_cnt <= '0;
        idx <= '0;
        addr <= '0;
        overflow <= 1'b0;
      end else begin
        if (take) begin
          pix_cnt <= pix_cnt + 1'b1;
          idx <= idx + 1'b1;
          if (idx == '0) word <= WORD_W'(pix);
          else word[PIX_W*idx +: PIX_W] <= pix;
        end
        if (pop) addr <= addr + 1'b1;
        if (push_q && full && !pop) overflow <= 1'b1;
      end
    end
endmodule

// File: tb/tb_conv_result_writer.sv
// tb_conv_result_writer: directed frames on a 5x5 writer covering packing, conversion, backpressure, overflow, tail flush and reset.
module tb_conv_result_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic data_valid = 1'b0;
  logic [7:0] data_in = '0;
  logic busy, frame_done, overflow;
  int n_cmp = 0;
  int n_err = 0;
  int fd_cnt = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0] pa[25] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                         8'hFB, 8'h80, 8'h7F, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                         8'hFF, 8'h40, 8'h55, 8'h66, 8'h10, 8'h20, 8'h30, 8'h70, 8'h09};
  conv_result_writer_if #(.ADDR_W(12)) mem ();
  conv_result_writer #(.OUT_W(5), .OUT_H(5), .ADDR_W(12), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .data_in(data_in),
    .data_valid(data_valid),
    .mem(mem),
    .busy(busy),
    .frame_done(frame_done),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (mem.mem_wr_en && mem.mem_wr_ready) begin
      wa.push_back(32'(mem.mem_wr_addr));
      wd.push_back(mem.mem_wr_data);
    end
    if (frame_done) fd_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pixel(input logic [7:0] v);
    data_in = v;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic seq_pixels(input int first, input int last);
    for (int i = first; i <= last; i++) pixel(8'(i));
  endtask
  task automatic wait_done(input string tag);
    int t, f0;
    t = 0;
    f0 = fd_cnt;
    while (!frame_done && t < 100) begin
      tick();
      t++;
    end
    check({tag, "_done"}, 32'(frame_done), 1);
    tick();
    check({tag, "_done_pulse"}, 32'(frame_done), 0);
    check({tag, "_done_once"}, 32'(fd_cnt - f0), 1);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask
  task automatic check_writes(input string tag, input logic [31:0] exp[$]);
    check({tag, "_nwr"}, 32'(wa.size()), 32'(exp.size()));
    foreach (exp[i])
      if (i < wa.size()) begin
        check($sformatf("%s_addr%0d", tag, i), wa[i], 32'(i));
        check($sformatf("%s_data%0d", tag, i), wd[i], exp[i]);
      end
    wa.delete();
    wd.delete();
  endtask
  initial begin
    logic [31:0] ex_a[$];
    logic [31:0] ex_seq[$];
    logic [31:0] ex_ovf[$];
    int f0;
`ifdef CONV_WR_ABS_MODE_EN
    ex_a = '{32'h04030201, 32'h08070605, 32'h007F8005, 32'h44332211, 32'h66554001, 32'h70302010, 32'h00000009};
`else
    ex_a = '{32'h04030201, 32'h08070605, 32'h007F0000, 32'h44332211, 32'h66554000, 32'h70302010, 32'h00000009};
`endif
    ex_seq = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D, 32'h14131211, 32'h18171615, 32'h00000019};
    ex_ovf = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D, 32'h00000019};
    mem.mem_wr_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_en", 32'(mem.mem_wr_en), 0);
    check("rst_addr", 32'(mem.mem_wr_addr), 0);
    check("rst_data", mem.mem_wr_data, 0);
    rst_n = 1'b1;
    mem.mem_wr_ready = 1'b1;
    tick();
    repeat (3) pixel(8'h55);
    repeat (3) tick();
    check("idle_ignore", 32'(wa.size()), 0);
    pulse_start();
    check("a_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) pixel(pa[i]);
    check("a_lat1_en", 32'(mem.mem_wr_en), 0);
    pixel(pa[4]);
    check("a_lat2_en", 32'(mem.mem_wr_en), 1);
    check("a_lat2_data", mem.mem_wr_data, 32'h04030201);
    for (int i = 5; i < 25; i++) begin
      start = i == 9;
      pixel(pa[i]);
    end
    start = 1'b0;
    pixel(8'hAA);
    pixel(8'hAA);
    wait_done("a");
    check("a_ovf", 32'(overflow), 0);
    check_writes("a", ex_a);
    mem.mem_wr_ready = 1'b0;
    pulse_start();
    seq_pixels(1, 12);
    repeat (8) tick();
    check("bp_en", 32'(mem.mem_wr_en), 1);
    check("bp_addr", 32'(mem.mem_wr_addr), 0);
    check("bp_data", mem.mem_wr_data, 32'h04030201);
    check("bp_ovf", 32'(overflow), 0);
    mem.mem_wr_ready = 1'b1;
    seq_pixels(13, 25);
    wait_done("bp");
    check_writes("bp", ex_seq);
    mem.mem_wr_ready = 1'b0;
    pulse_start();
    seq_pixels(1, 24);
    repeat (3) tick();
    check("ovf_set", 32'(overflow), 1);
    check("ovf_busy", 32'(busy), 1);
    mem.mem_wr_ready = 1'b1;
    pixel(8'd25);
    wait_done("ovf");
    check("ovf_sticky", 32'(overflow), 1);
    check_writes("ovf", ex_ovf);
    pulse_start();
    check("ovf_clear", 32'(overflow), 0);
    seq_pixels(1, 5);
    rst_n = 1'b0;
    tick();
    check("mrst_busy", 32'(busy), 0);
    check("mrst_en", 32'(mem.mem_wr_en), 0);
    check("mrst_addr", 32'(mem.mem_wr_addr), 0);
    check("mrst_data", mem.mem_wr_data, 0);
    check("mrst_done", 32'(frame_done), 0);
    rst_n = 1'b1;
    wa.delete();
    wd.delete();
    f0 = fd_cnt;
    repeat (10) tick();
    check("mrst_no_done", 32'(fd_cnt - f0), 0);
    check("mrst_no_wr", 32'(wa.size()), 0);
    pulse_start();
    seq_pixels(1, 25);
    wait_done("re");
    check_writes("re", ex_seq);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
